// File: rtl/btn_debouncer.sv
// Per-channel push-button debouncer: 2-flop synchroniser, stability-count FSM, clean level plus press/release pulses.
// Define BTN_DEBOUNCE_LONGPRESS_EN to add a one-shot long-press pulse per channel.
module btn_debouncer #(
  parameter int NB_BTN         = 4,
  parameter int NB_CNT         = 20,
  parameter int DEBOUNCE_LIMIT = 1000000,
  parameter int LONG_LIMIT     = 50000000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NB_BTN-1:0] i_btn,
  output logic [NB_BTN-1:0] o_btn_level,
  output logic [NB_BTN-1:0] o_btn_press,
  output logic [NB_BTN-1:0] o_btn_release,
  output logic [NB_BTN-1:0] o_btn_long
);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

  // The entering observation counts as the first, so a change is accepted on
  // the DEBOUNCE_LIMIT-th consecutive observation of the new value.
  localparam logic [NB_CNT-1:0] LIMIT_M1 = NB_CNT'(DEBOUNCE_LIMIT - 1);
  localparam bit                LIMIT_IS_ONE = (DEBOUNCE_LIMIT == 1);

  logic [NB_BTN-1:0] sync1, sync2;
  state_t            state [NB_BTN];
  logic [NB_CNT-1:0] cnt   [NB_BTN];
  logic [NB_BTN-1:0] press_acc, rel_acc;

  always_comb begin
    press_acc = '0;
    rel_acc   = '0;
    for (int i = 0; i < NB_BTN; i++) begin
      press_acc[i] = sync2[i] &&
                     ((state[i] == RELEASED && LIMIT_IS_ONE) ||
                      (state[i] == PRESS_WAIT && cnt[i] == LIMIT_M1));
      rel_acc[i]   = !sync2[i] &&
                     ((state[i] == PRESSED && LIMIT_IS_ONE) ||
                      (state[i] == RELEASE_WAIT && cnt[i] == LIMIT_M1));
    end
  end

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // the pulse defaults below are then overridden within the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1         <= '0;
      sync2         <= '0;
      o_btn_level   <= '0;
      o_btn_press   <= '0;
      o_btn_release <= '0;
      for (int i = 0; i < NB_BTN; i++) begin
        state[i] <= RELEASED;
        cnt[i]   <= '0;
      end
    end else begin
      sync1         <= i_btn;
      sync2         <= sync1;
      o_btn_press   <= '0;
      o_btn_release <= '0;
      for (int i = 0; i < NB_BTN; i++) begin
        if (press_acc[i]) begin
          state[i]       <= PRESSED;
          cnt[i]         <= '0;
          o_btn_level[i] <= 1'b1;
          o_btn_press[i] <= 1'b1;
        end else if (rel_acc[i]) begin
          state[i]         <= RELEASED;
          cnt[i]           <= '0;
          o_btn_level[i]   <= 1'b0;
          o_btn_release[i] <= 1'b1;
        end else begin
          case (state[i])
            RELEASED: begin
              if (sync2[i]) begin
                state[i] <= PRESS_WAIT;
                cnt[i]   <= NB_CNT'(1);
              end else begin
                cnt[i] <= '0;
              end
            end
            PRESS_WAIT: begin
              if (!sync2[i]) begin
                state[i] <= RELEASED;
                cnt[i]   <= '0;
              end else begin
                cnt[i] <= cnt[i] + NB_CNT'(1);
              end
            end
            PRESSED: begin
              if (!sync2[i]) begin
                state[i] <= RELEASE_WAIT;
                cnt[i]   <= NB_CNT'(1);
              end else begin
                cnt[i] <= '0;
              end
            end
            RELEASE_WAIT: begin
              if (sync2[i]) begin
                state[i] <= PRESSED;
                cnt[i]   <= '0;
              end else begin
                cnt[i] <= cnt[i] + NB_CNT'(1);
              end
            end
            default: begin
              state[i] <= RELEASED;
              cnt[i]   <= '0;
            end
          endcase
        end
      end
    end
  end

`ifdef BTN_DEBOUNCE_LONGPRESS_EN
  localparam int              HOLD_W    = $clog2(LONG_LIMIT + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_LIMIT);
  localparam logic [HOLD_W-1:0] HOLD_M1  = HOLD_W'(LONG_LIMIT - 1);

  logic [HOLD_W-1:0] hold [NB_BTN];

  // Hold time counts while the button is accepted as down; saturating at the
  // limit makes the long pulse fire at most once per press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      o_btn_long <= '0;
      for (int i = 0; i < NB_BTN; i++) hold[i] <= '0;
    end else begin
      o_btn_long <= '0;
      for (int i = 0; i < NB_BTN; i++) begin
        if ((state[i] == PRESSED || state[i] == RELEASE_WAIT) && !rel_acc[i]) begin
          if (hold[i] != HOLD_MAX) begin
            hold[i]       <= hold[i] + HOLD_W'(1);
            o_btn_long[i] <= (hold[i] == HOLD_M1);
          end
        end else begin
          hold[i] <= '0;
        end
      end
    end
  end
`else
  // Constant zero; the comparison only keeps LONG_LIMIT referenced.
  assign o_btn_long = {NB_BTN{LONG_LIMIT < 0}};
`endif

endmodule
